// File: rtl/minirv_pkg.sv
// minirv_pkg: shared types and default sizes for the minirv register file.
//   XLEN     register width
//   NREGS    number of architectural registers (16 for RV32E builds)
//   RW       register index width
//   word_t   one register value
//   regidx_t one register index
package minirv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RW    = $clog2(NREGS);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [RW-1:0]   regidx_t;

endpackage

// File: rtl/minirv_rf_readport.sv
// minirv_rf_readport: one combinational register-file read port.
//   rf_flat  in   registered register image, register i at [XLEN*i +: XLEN]
//   addr     in   register to read
//   wr_en    in   a register write is being accepted this cycle
//   wr_rd    in   destination of that write
//   wr_data  in   value of that write
//   data     out  x0 and out-of-range addresses read 0; with BYPASS a write to
//                 the same register in this cycle is forwarded, else the stored value
module minirv_rf_readport #(
  parameter int XLEN   = minirv_pkg::XLEN,
  parameter int NREGS  = minirv_pkg::NREGS,
  parameter bit BYPASS = 1'b1,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic [NREGS*XLEN-1:0] rf_flat,
  input  logic [RW-1:0]         addr,
  input  logic                  wr_en,
  input  logic [RW-1:0]         wr_rd,
  input  logic [XLEN-1:0]       wr_data,
  output logic [XLEN-1:0]       data
);

  localparam logic [RW:0] NREGS_W = (RW+1)'(NREGS);

  logic [XLEN-1:0] words [NREGS];
  logic            in_range;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_unflat
      assign words[gi] = rf_flat[gi*XLEN +: XLEN];
    end
  endgenerate

  // Only matters when NREGS is not a power of two.
  assign in_range = ({1'b0, addr} < NREGS_W);

  always_comb begin
    data = '0;
    if (addr == '0 || !in_range) begin
      data = '0;
    end else if (BYPASS && wr_en && (wr_rd == addr)) begin
      data = wr_data;
    end else begin
      data = words[addr];
    end
  end

endmodule

// File: rtl/minirv_regfile_wb.sv
// minirv_regfile_wb: architectural integer register file with a handshaked
// write-back port, two combinational read ports and a flattened snapshot.
//   clock        posedge clock
//   reset        asynchronous active-low reset
//   wb_valid     write-back request valid
//   wb_ready     request accepted when wb_valid & wb_ready (= reset & ~dbg_freeze)
//   wb_rd        destination register
//   wb_data      value to write
//   wb_wen       0 = retire without a register write
//   dbg_freeze   hold all state and stall write-back
//   rs1_addr/rs1_data, rs2_addr/rs2_data   combinational read ports
//   rf_flat      registered image, register i at [XLEN*i +: XLEN]
//   commit_valid one-cycle pulse the cycle after each accepted request
//   commit_rd    rd of the committed request (0 when no register was written)
//   commit_count accepted requests since reset, wraps at 2^32
module minirv_regfile_wb #(
  parameter int NREGS  = minirv_pkg::NREGS,
  parameter int XLEN   = minirv_pkg::XLEN,
  parameter bit BYPASS = 1'b1,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [RW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  wb_wen,
  input  logic                  dbg_freeze,
  input  logic [RW-1:0]         rs1_addr,
  output logic [XLEN-1:0]       rs1_data,
  input  logic [RW-1:0]         rs2_addr,
  output logic [XLEN-1:0]       rs2_data,
  output logic [NREGS*XLEN-1:0] rf_flat,
  output logic                  commit_valid,
  output logic [RW-1:0]         commit_rd,
  output logic [31:0]           commit_count
);

  localparam logic [RW:0] NREGS_W = (RW+1)'(NREGS);

  logic          accept;
  logic          wr_en;
  logic          wr_hit;
  logic          commit_valid_reg;
  logic [RW-1:0] commit_rd_reg;
  logic [31:0]   commit_count_reg;

  assign wb_ready = reset & ~dbg_freeze;
  assign accept   = wb_valid & wb_ready;
  assign wr_en    = accept & wb_wen;
  // x0 and out-of-range destinations retire normally but leave storage untouched.
  assign wr_hit   = wr_en & (wb_rd != '0) & ({1'b0, wb_rd} < NREGS_W);

  // Each register is its own flop bank so the whole image can be cleared on
  // reset and exported every cycle; x0 has no storage at all.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_flat[XLEN-1:0] = '0;
      end else begin : g_store
        logic [XLEN-1:0] q_reg;
        always_ff @(posedge clock or negedge reset) begin
          if (!reset) begin
            q_reg <= '0;
          end else if (wr_hit && (wb_rd == RW'(gi))) begin
            q_reg <= wb_data;
          end
        end
        assign rf_flat[gi*XLEN +: XLEN] = q_reg;
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_valid_reg <= 1'b0;
      commit_rd_reg    <= '0;
      commit_count_reg <= '0;
    end else begin
      commit_valid_reg <= accept;
      if (accept) begin
        commit_rd_reg    <= wb_wen ? wb_rd : '0;
        commit_count_reg <= commit_count_reg + 32'd1;
      end
    end
  end

  assign commit_valid = commit_valid_reg;
  assign commit_rd    = commit_rd_reg;
  assign commit_count = commit_count_reg;

  minirv_rf_readport #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_rs1 (
    .rf_flat (rf_flat),
    .addr    (rs1_addr),
    .wr_en   (wr_en),
    .wr_rd   (wb_rd),
    .wr_data (wb_data),
    .data    (rs1_data)
  );

  minirv_rf_readport #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_rs2 (
    .rf_flat (rf_flat),
    .addr    (rs2_addr),
    .wr_en   (wr_en),
    .wr_rd   (wb_rd),
    .wr_data (wb_data),
    .data    (rs2_data)
  );

endmodule
